// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS core pipeline stages.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [PC_W-1:0]    RESET_PC_DEF = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR    = 32'h0000_0000;

    // Word-align a redirect target; instruction fetches are always word accesses.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/flopenr_n.sv
// Enable flop with synchronous active-low reset to a parameterised value.
module flopenr_n #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d when enabled; reset wins over enable.
    always_ff @(posedge clk) begin
        if (!reset_n)
            q <= RESET_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, deferred redirect
// while stalled, and the IF/ID pipeline register.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int               IMEM_AW  = 6,
    parameter logic [PC_W-1:0]  RESET_PC = RESET_PC_DEF,
    parameter int               CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                stall_f,
    input  logic                stall_d,
    input  logic                flush_d,
    input  logic                pc_src_d,
    input  logic [PC_W-1:0]     pc_branch_d,
    input  logic                jump_d,
    input  logic [PC_W-1:0]     pc_jump_d,
    output logic [IMEM_AW-1:0]  imem_addr,
    input  logic [INSTR_W-1:0]  imem_rd,
    output logic [PC_W-1:0]     pc_f,
    output logic [INSTR_W-1:0]  instr_d,
    output logic [PC_W-1:0]     pc_plus4_d,
    output logic                valid_d,
    output logic                misalign_err,
    output logic [CNT_W-1:0]    fetch_count
);

    logic              redirect;
    logic [PC_W-1:0]   redir_raw;
    logic [PC_W-1:0]   redir_tgt;
    logic [PC_W-1:0]   pc_plus4;
    logic [PC_W-1:0]   pc_next;
    logic              pend_v;
    logic [PC_W-1:0]   pend_pc;
    logic              ifid_load;

    // Jump outranks branch; a live redirect outranks one deferred by stall_f.
    always_comb begin
        redirect  = jump_d | pc_src_d;
        redir_raw = jump_d ? pc_jump_d : pc_branch_d;
        redir_tgt = align_pc(redir_raw);
        pc_plus4  = pc_f + 32'd4;
        if (redirect)
            pc_next = redir_tgt;
        else if (pend_v)
            pc_next = pend_pc;
        else
            pc_next = pc_plus4;
    end

    assign imem_addr = pc_f[IMEM_AW+1:2];
    assign ifid_load = ~stall_d;

    flopenr_n #(.WIDTH(PC_W), .RESET_VAL(RESET_PC)) u_pc (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (~stall_f),
        .d       (pc_next),
        .q       (pc_f)
    );

    // Target of a redirect that arrived while stall_f held the PC; latest wins.
    flopenr_n #(.WIDTH(PC_W), .RESET_VAL('0)) u_pend_pc (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (stall_f & redirect),
        .d       (redir_tgt),
        .q       (pend_pc)
    );

    // Pending flag sets on a stalled redirect and clears once the PC moves.
    always_ff @(posedge clk) begin
        if (!reset_n)
            pend_v <= 1'b0;
        else if (stall_f && redirect)
            pend_v <= 1'b1;
        else if (!stall_f)
            pend_v <= 1'b0;
    end

    flopenr_n #(.WIDTH(INSTR_W), .RESET_VAL(NOP_INSTR)) u_instr_d (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (ifid_load),
        .d       (flush_d ? NOP_INSTR : imem_rd),
        .q       (instr_d)
    );

    flopenr_n #(.WIDTH(PC_W), .RESET_VAL('0)) u_pc_plus4_d (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (ifid_load),
        .d       (flush_d ? '0 : pc_plus4),
        .q       (pc_plus4_d)
    );

    flopenr_n #(.WIDTH(1), .RESET_VAL(1'b0)) u_valid_d (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (ifid_load),
        .d       (~flush_d),
        .q       (valid_d)
    );

    // Sticky flag for any redirect whose selected target was not word aligned.
    always_ff @(posedge clk) begin
        if (!reset_n)
            misalign_err <= 1'b0;
        else if (redirect && (redir_raw[1:0] != 2'b00))
            misalign_err <= 1'b1;
    end

    // Count real instructions entering IF/ID, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!reset_n)
            fetch_count <= '0;
        else if (ifid_load && !flush_d && (fetch_count != '1))
            fetch_count <= fetch_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a pattern-filled instruction memory.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall_f, stall_d, flush_d;
    logic        pc_src_d, jump_d;
    logic [31:0] pc_branch_d, pc_jump_d;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rd;
    logic [31:0] pc_f, instr_d, pc_plus4_d;
    logic        valid_d, misalign_err;
    logic [15:0] fetch_count;

    logic [31:0] imem [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_rd = imem[imem_addr];

    fetch_stage dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .pc_src_d     (pc_src_d),
        .pc_branch_d  (pc_branch_d),
        .jump_d       (jump_d),
        .pc_jump_d    (pc_jump_d),
        .imem_addr    (imem_addr),
        .imem_rd      (imem_rd),
        .pc_f         (pc_f),
        .instr_d      (instr_d),
        .pc_plus4_d   (pc_plus4_d),
        .valid_d      (valid_d),
        .misalign_err (misalign_err),
        .fetch_count  (fetch_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        stall_f = 0; stall_d = 0; flush_d = 0;
        pc_src_d = 0; jump_d = 0;
        pc_branch_d = 32'h0; pc_jump_d = 32'h0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = {16'hC0DE, 16'(i)};
        quiet();
        reset_n = 0;
        step(); step();
        check("rst_pc",     pc_f, 32'h0);
        check("rst_instr",  instr_d, 32'h0);
        check("rst_pc4",    pc_plus4_d, 32'h0);
        check("rst_valid",  32'(valid_d), 32'h0);
        check("rst_mis",    32'(misalign_err), 32'h0);
        check("rst_cnt",    32'(fetch_count), 32'h0);
        check("rst_iaddr",  32'(imem_addr), 32'h0);

        // free-running fetch
        reset_n = 1;
        step();
        check("run1_pc",    pc_f, 32'h4);
        check("run1_instr", instr_d, 32'hC0DE_0000);
        check("run1_pc4",   pc_plus4_d, 32'h4);
        check("run1_valid", 32'(valid_d), 32'h1);
        step();
        check("run2_pc",    pc_f, 32'h8);
        check("run2_instr", instr_d, 32'hC0DE_0001);
        check("run2_cnt",   32'(fetch_count), 32'h2);

        // stall both at pc_f=8 for 3 cycles
        stall_f = 1; stall_d = 1;
        step(); step(); step();
        check("stall_pc",    pc_f, 32'h8);
        check("stall_instr", instr_d, 32'hC0DE_0001);
        check("stall_cnt",   32'(fetch_count), 32'h2);
        check("stall_valid", 32'(valid_d), 32'h1);
        quiet();
        step();
        check("rel_pc",    pc_f, 32'hC);
        check("rel_instr", instr_d, 32'hC0DE_0002);
        check("rel_pc4",   pc_plus4_d, 32'hC);
        check("rel_cnt",   32'(fetch_count), 32'h3);
        step();
        check("rel2_pc",    pc_f, 32'h10);
        check("rel2_instr", instr_d, 32'hC0DE_0003);
        check("rel2_cnt",   32'(fetch_count), 32'h4);

        // taken branch with flush
        pc_src_d = 1; pc_branch_d = 32'h40; flush_d = 1;
        step();
        check("br_pc",    pc_f, 32'h40);
        check("br_valid", 32'(valid_d), 32'h0);
        check("br_instr", instr_d, 32'h0);
        check("br_pc4",   pc_plus4_d, 32'h0);
        check("br_cnt",   32'(fetch_count), 32'h4);
        quiet();
        step();
        check("br2_pc",    pc_f, 32'h44);
        check("br2_instr", instr_d, 32'hC0DE_0010);
        check("br2_pc4",   pc_plus4_d, 32'h44);
        check("br2_cnt",   32'(fetch_count), 32'h5);

        // jump beats branch
        jump_d = 1; pc_jump_d = 32'h80; pc_src_d = 1; pc_branch_d = 32'h40; flush_d = 1;
        step();
        check("jmp_pc",  pc_f, 32'h80);
        check("jmp_mis", 32'(misalign_err), 32'h0);
        quiet();
        step();
        check("jmp2_pc",    pc_f, 32'h84);
        check("jmp2_instr", instr_d, 32'hC0DE_0020);
        check("jmp2_iaddr", 32'(imem_addr), 32'd33);

        // redirect deferred by stall_f
        stall_f = 1; stall_d = 1; pc_src_d = 1; pc_branch_d = 32'h20;
        step();
        check("dfr1_pc", pc_f, 32'h84);
        pc_src_d = 0; pc_branch_d = 32'h0;
        step();
        check("dfr2_pc", pc_f, 32'h84);
        stall_f = 0; stall_d = 0;
        step();
        check("dfr3_pc",    pc_f, 32'h20);
        check("dfr3_instr", instr_d, 32'hC0DE_0021);
        check("dfr3_cnt",   32'(fetch_count), 32'h7);

        // two redirects during a stall: the later wins
        stall_f = 1; stall_d = 1; pc_src_d = 1; pc_branch_d = 32'h28;
        step();
        pc_src_d = 0; jump_d = 1; pc_jump_d = 32'h30;
        step();
        check("ovr_hold", pc_f, 32'h20);
        quiet();
        step();
        check("ovr_pc",    pc_f, 32'h30);
        check("ovr_instr", instr_d, 32'hC0DE_0008);
        check("ovr_cnt",   32'(fetch_count), 32'h8);
        step();
        check("ovr2_pc",    pc_f, 32'h34);
        check("ovr2_instr", instr_d, 32'hC0DE_000C);
        check("ovr2_cnt",   32'(fetch_count), 32'h9);

        // stall_d overrides flush_d; misaligned target
        stall_d = 1; flush_d = 1; pc_src_d = 1; pc_branch_d = 32'h42;
        step();
        check("sd_instr", instr_d, 32'hC0DE_000C);
        check("sd_valid", 32'(valid_d), 32'h1);
        check("sd_pc4",   pc_plus4_d, 32'h34);
        check("sd_cnt",   32'(fetch_count), 32'h9);
        check("mis_pc",   pc_f, 32'h40);
        check("mis_err",  32'(misalign_err), 32'h1);
        quiet();
        step();
        check("mis_sticky", 32'(misalign_err), 32'h1);
        check("mis2_instr", instr_d, 32'hC0DE_0010);
        check("mis2_cnt",   32'(fetch_count), 32'hA);

        // imem address aliasing beyond 64 words
        jump_d = 1; pc_jump_d = 32'h104;
        step();
        quiet();
        check("alias_iaddr", 32'(imem_addr), 32'h1);
        step();
        check("alias_instr", instr_d, 32'hC0DE_0001);

        // reset mid-stall with a pending redirect discards it
        stall_f = 1; stall_d = 1; pc_src_d = 1; pc_branch_d = 32'h80;
        reset_n = 0;
        step();
        check("rst2_pc",    pc_f, 32'h0);
        check("rst2_mis",   32'(misalign_err), 32'h0);
        check("rst2_cnt",   32'(fetch_count), 32'h0);
        check("rst2_valid", 32'(valid_d), 32'h0);
        quiet();
        reset_n = 1;
        step();
        check("rst3_pc",    pc_f, 32'h4);
        check("rst3_instr", instr_d, 32'hC0DE_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
